// File: rtl/encrypt_config.sv
// Shared constants and round functions for the 3-round XOR/bit-permutation
// cipher, so the encrypter and decrypter use one definition.
package encrypt_config;

    // Forward permutation: out[i] = in[PERM[i]] (entry 0 is the rightmost)
    localparam logic [7:0][2:0] PERM = {3'd4, 3'd3, 3'd7, 3'd6, 3'd5, 3'd2, 3'd1, 3'd0};
    // Inverse permutation: out[j] = in[INV[j]], so PERM[INV[j]] == j
    localparam logic [7:0][2:0] INV  = {3'd5, 3'd4, 3'd3, 3'd7, 3'd6, 3'd2, 3'd1, 3'd0};

    localparam logic [7:0] K1_DEFAULT = 8'h67;
    localparam logic [7:0] K2_DEFAULT = 8'd167;
    localparam logic [7:0] K3_DEFAULT = 8'd221;

    typedef logic [1:0] key_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } dec_state_t;

    function automatic logic [7:0] perm_fwd(input logic [7:0] x);
        logic [7:0] y;
        y = '0;
        for (int i = 0; i < 8; i++) y[i] = x[PERM[i]];
        return y;
    endfunction

    function automatic logic [7:0] perm_inv(input logic [7:0] x);
        logic [7:0] y;
        y = '0;
        for (int i = 0; i < 8; i++) y[i] = x[INV[i]];
        return y;
    endfunction

    // One encrypt round: x = P(x ^ K)
    function automatic logic [7:0] enc_round(input logic [7:0] x, input logic [7:0] key);
        return perm_fwd(x ^ key);
    endfunction

    // One decrypt round: x = Pinv(x) ^ K
    function automatic logic [7:0] dec_round(input logic [7:0] x, input logic [7:0] key);
        return perm_inv(x) ^ key;
    endfunction

endpackage

// File: rtl/decrypt_round.sv
// Combinational decrypt round: y = Pinv(x) ^ key. Pure wiring plus an XOR.
module decrypt_round
    import encrypt_config::*;
(
    input  logic [7:0] x,
    input  logic [7:0] key,
    output logic [7:0] y
);

    assign y = dec_round(x, key);

endmodule

// File: rtl/decrypt_core.sv
// Streaming 8-bit decrypter. HP_MODE=1: three-stage stall-chain pipeline,
// one byte per cycle. HP_MODE=0: one shared round unit stepped by a small FSM.
module decrypt_core
    import encrypt_config::*;
#(
    parameter int HP_MODE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    input  logic       cfg_we,
    input  logic [1:0] cfg_sel,
    input  logic [7:0] cfg_data,
    output logic       idle
);

    logic [7:0] k1_q, k1_d, k2_q, k2_d, k3_q, k3_d;

    // Key writes land only when nothing is in flight and nothing is arriving
    always_comb begin
        k1_d = k1_q;
        k2_d = k2_q;
        k3_d = k3_q;
        if (cfg_we && idle && !in_valid) begin
            case (key_idx_t'(cfg_sel))
                2'd1:    k1_d = cfg_data;
                2'd2:    k2_d = cfg_data;
                2'd3:    k3_d = cfg_data;
                default: ;
            endcase
        end
    end

    // Key registers, restored to package defaults on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            k1_q <= K1_DEFAULT;
            k2_q <= K2_DEFAULT;
            k3_q <= K3_DEFAULT;
        end else begin
            k1_q <= k1_d;
            k2_q <= k2_d;
            k3_q <= k3_d;
        end
    end

    if (HP_MODE != 0) begin : g_pipe
        // Each stage register holds the byte after its round has been applied,
        // so out_data comes straight from the S1 register.
        logic [7:0] s3_q, s3_d, s2_q, s2_d, s1_q, s1_d;
        logic       v3_q, v3_d, v2_q, v2_d, v1_q, v1_d;
        logic [7:0] r3, r2, r1;
        logic       adv3, adv2, adv1;

        decrypt_round u_round3 (.x(in_data), .key(k3_q), .y(r3));
        decrypt_round u_round2 (.x(s3_q),    .key(k2_q), .y(r2));
        decrypt_round u_round1 (.x(s2_q),    .key(k1_q), .y(r1));

        // Stall chain: a stage moves when empty or when its successor moves
        always_comb begin
            adv1 = !v1_q || out_ready;
            adv2 = !v2_q || adv1;
            adv3 = !v3_q || adv2;
            s3_d = s3_q;
            s2_d = s2_q;
            s1_d = s1_q;
            v3_d = v3_q;
            v2_d = v2_q;
            v1_d = v1_q;
            if (adv3) begin
                v3_d = in_valid;
                if (in_valid) s3_d = r3;
            end
            if (adv2) begin
                v2_d = v3_q;
                if (v3_q) s2_d = r2;
            end
            if (adv1) begin
                v1_d = v2_q;
                if (v2_q) s1_d = r1;
            end
        end

        // Stage registers; reset drops every in-flight byte
        always_ff @(posedge clk) begin
            if (reset) begin
                s3_q <= '0;
                s2_q <= '0;
                s1_q <= '0;
                v3_q <= 1'b0;
                v2_q <= 1'b0;
                v1_q <= 1'b0;
            end else begin
                s3_q <= s3_d;
                s2_q <= s2_d;
                s1_q <= s1_d;
                v3_q <= v3_d;
                v2_q <= v2_d;
                v1_q <= v1_d;
            end
        end

        assign in_ready  = adv3;
        assign out_valid = v1_q;
        assign out_data  = s1_q;
        assign idle      = !(v1_q || v2_q || v3_q);

    end else begin : g_iter
        dec_state_t state_q, state_d;
        key_idx_t   cnt_q, cnt_d, rsel;
        logic [7:0] data_q, data_d;
        logic [7:0] rx, rk, ry;

        decrypt_round u_round (.x(rx), .key(rk), .y(ry));

        // Round 3 is applied while latching the input byte; RUN then applies
        // round cnt-1, so three rounds fit into accept + two RUN cycles.
        always_comb begin
            rsel = (state_q == ST_IDLE) ? key_idx_t'(2'd3) : key_idx_t'(cnt_q - 2'd1);
            rx   = (state_q == ST_IDLE) ? in_data : data_q;
            case (rsel)
                2'd1:    rk = k1_q;
                2'd2:    rk = k2_q;
                default: rk = k3_q;
            endcase
        end

        // Next-state logic: IDLE -> RUN (x2) -> DONE -> IDLE
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            data_d  = data_q;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        data_d  = ry;
                        cnt_d   = 2'd3;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    data_d = ry;
                    cnt_d  = cnt_q - 2'd1;
                    if (cnt_d == 2'd1) state_d = ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // State, round counter and data register
        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                data_q  <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                data_q  <= data_d;
            end
        end

        assign in_ready  = (state_q == ST_IDLE);
        assign out_valid = (state_q == ST_DONE);
        assign out_data  = data_q;
        assign idle      = (state_q == ST_IDLE);
    end

endmodule

// File: tb/tb_decrypt_core.sv
// Bench for decrypt_core: one pipelined and one iterative instance side by side.
module tb_decrypt_core;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       iv_h, ir_h, ov_h, ordy_h, idle_h, we_h;
    logic [7:0] id_h, od_h;
    logic       iv_i, ir_i, ov_i, ordy_i, idle_i, we_i;
    logic [7:0] id_i, od_i;
    logic [1:0] cfg_sel;
    logic [7:0] cfg_data;

    decrypt_core #(.HP_MODE(1)) dut_hp (
        .clk(clk), .reset(reset), .in_valid(iv_h), .in_ready(ir_h), .in_data(id_h),
        .out_valid(ov_h), .out_ready(ordy_h), .out_data(od_h),
        .cfg_we(we_h), .cfg_sel(cfg_sel), .cfg_data(cfg_data), .idle(idle_h));

    decrypt_core #(.HP_MODE(0)) dut_it (
        .clk(clk), .reset(reset), .in_valid(iv_i), .in_ready(ir_i), .in_data(id_i),
        .out_valid(ov_i), .out_ready(ordy_i), .out_data(od_i),
        .cfg_we(we_i), .cfg_sel(cfg_sel), .cfg_data(cfg_data), .idle(idle_i));

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Key model, shared by both instances (they receive the same config writes)
    logic [7:0] km1 = 8'h67, km2 = 8'd167, km3 = 8'd221;

    function automatic logic [7:0] pperm(input logic [7:0] x);
        return {x[4], x[3], x[7], x[6], x[5], x[2], x[1], x[0]};
    endfunction

    function automatic logic [7:0] enc(input logic [7:0] p);
        logic [7:0] x;
        x = pperm(p ^ km1);
        x = pperm(x ^ km2);
        x = pperm(x ^ km3);
        return x;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic f_ir(input bit m); return m ? ir_h : ir_i; endfunction
    function automatic logic f_ov(input bit m); return m ? ov_h : ov_i; endfunction
    function automatic logic [7:0] f_od(input bit m); return m ? od_h : od_i; endfunction

    // Single byte through one instance with out_ready high; latency counted in cycles
    task automatic xfer(input bit m, input logic [7:0] c, output logic [7:0] d,
                        output int lat, output bit ok);
        int w;
        ok = 1'b1;
        if (m) begin iv_h = 1'b1; id_h = c; end else begin iv_i = 1'b1; id_i = c; end
        w = 0;
        @(negedge clk);
        while (!f_ir(m) && w < 20) begin @(negedge clk); w++; end
        if (!f_ir(m)) ok = 1'b0;
        @(posedge clk); #1;
        if (m) iv_h = 1'b0; else iv_i = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!f_ov(m) && lat < 20) begin @(negedge clk); lat++; end
        if (!f_ov(m)) ok = 1'b0;
        d = f_od(m);
        @(posedge clk); #1;
    endtask

    task automatic run_vec(input bit m, input logic [7:0] c, input logic [7:0] pe, input string nm);
        logic [7:0] d;
        int lat;
        bit ok;
        xfer(m, c, d, lat, ok);
        check($sformatf("%s_m%0d_handshake", nm, m), int'(ok), 1);
        check($sformatf("%s_m%0d_data", nm, m), int'(d), int'(pe));
        check($sformatf("%s_m%0d_latency", nm, m), lat, 3);
    endtask

    // Scoreboard for the pipelined instance
    logic [7:0] sb[$];
    int acc_cyc[$];
    int out_cyc[$];
    int rx_cnt = 0;
    bit mon_en = 1'b0;

    always @(negedge clk) begin : mon
        logic [7:0] e;
        if (mon_en && ov_h && ordy_h) begin
            out_cyc.push_back(cyc);
            rx_cnt++;
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL hp_unexpected_out: got %0h expected no output", od_h);
            end else begin
                e = sb.pop_front();
                check("hp_stream_data", int'(od_h), int'(e));
            end
        end
    end

    task automatic stream_h(input int n);
        for (int k = 0; k < n; k++) begin
            logic [7:0] pt;
            int w;
            pt = 8'($urandom);
            w = 0;
            iv_h = 1'b1;
            id_h = enc(pt);
            @(negedge clk);
            while (!ir_h && w < 50) begin @(negedge clk); w++; end
            if (!ir_h) begin
                n_chk++;
                n_fail++;
                $display("FAIL hp_accept_timeout: got in_ready 0 expected 1");
            end else begin
                sb.push_back(pt);
                acc_cyc.push_back(cyc);
            end
            @(posedge clk); #1;
        end
        iv_h = 1'b0;
    endtask

    task automatic drain_h(input int n, input string nm);
        int w;
        w = 0;
        while (sb.size() != 0 && w < 30) begin @(negedge clk); w++; end
        @(posedge clk); #1;
        check({nm, "_sb_empty"}, sb.size(), 0);
        check({nm, "_rx_count"}, rx_cnt, n);
    endtask

    typedef struct packed {
        logic [7:0] cin;
        logic [7:0] pexp;
    } vec_t;

    vec_t vt [6];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int seen;
        int w;
        logic       irh [16];
        logic       ovh [16];
        logic [7:0] odh [16];
        logic [7:0] pt;

        // Reset, with a key write held during reset that must be ignored
        reset = 1'b1;
        iv_h = 1'b0; iv_i = 1'b0; id_h = '0; id_i = '0;
        ordy_h = 1'b1; ordy_i = 1'b1;
        we_h = 1'b1; we_i = 1'b1; cfg_sel = 2'd1; cfg_data = 8'h00;
        @(negedge clk);
        @(negedge clk);
        check("rst_hp_out_valid", int'(ov_h), 0);
        check("rst_hp_out_data", int'(od_h), 0);
        check("rst_hp_in_ready", int'(ir_h), 1);
        check("rst_hp_idle", int'(idle_h), 1);
        check("rst_it_out_valid", int'(ov_i), 0);
        check("rst_it_out_data", int'(od_i), 0);
        check("rst_it_in_ready", int'(ir_i), 1);
        check("rst_it_idle", int'(idle_i), 1);
        @(posedge clk); #1;
        reset = 1'b0; we_h = 1'b0; we_i = 1'b0;

        // Directed vectors, default keys
        vt[0] = '{cin: 8'h8D, pexp: 8'h00};
        vt[1] = '{cin: 8'h00, pexp: 8'h1D};
        vt[2] = '{cin: 8'hFF, pexp: 8'hE2};
        vt[3] = '{cin: enc(8'hA5), pexp: 8'hA5};
        vt[4] = '{cin: enc(8'h3C), pexp: 8'h3C};
        vt[5] = '{cin: enc(8'h81), pexp: 8'h81};
        for (int m = 1; m >= 0; m--)
            for (int i = 0; i < 6; i++)
                run_vec(m[0], vt[i].cin, vt[i].pexp, $sformatf("vec%0d", i));

        // 16 back-to-back bytes, out_ready high
        mon_en = 1'b1;
        rx_cnt = 0; acc_cyc.delete(); out_cyc.delete();
        stream_h(16);
        drain_h(16, "hp_stream16");
        for (int k = 0; k < 16; k++)
            if (k < out_cyc.size())
                check($sformatf("hp_stream16_out_cycle%0d", k), out_cyc[k], acc_cyc[0] + 3 + k);

        // 12 bytes with a 5-cycle out_ready stall once the pipe is full
        rx_cnt = 0;
        fork
            stream_h(12);
            begin
                repeat (4) @(posedge clk);
                #1 ordy_h = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    check($sformatf("hp_stall%0d_in_ready", s), int'(ir_h), 0);
                    check($sformatf("hp_stall%0d_out_valid", s), int'(ov_h), 1);
                end
                @(posedge clk); #1 ordy_h = 1'b1;
            end
        join
        drain_h(12, "hp_stall");
        mon_en = 1'b0;

        // Iterative: in_valid held high, one acceptance every 4 cycles
        pt = 8'h96;
        iv_i = 1'b1; id_i = enc(pt);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            irh[c] = ir_i; ovh[c] = ov_i; odh[c] = od_i;
        end
        @(posedge clk); #1 iv_i = 1'b0;
        for (int c = 0; c < 16; c++) begin
            check($sformatf("it_pulse_in_ready_c%0d", c), int'(irh[c]), int'(c % 4 == 0));
            check($sformatf("it_pulse_out_valid_c%0d", c), int'(ovh[c]), int'(c % 4 == 3));
            if (c % 4 == 3) check($sformatf("it_pulse_data_c%0d", c), int'(odh[c]), int'(pt));
        end
        @(posedge clk); #1;

        // Iterative: out_data holds while out_ready is low
        ordy_i = 1'b0; iv_i = 1'b1; id_i = enc(8'h4B);
        @(negedge clk);
        @(posedge clk); #1 iv_i = 1'b0;
        w = 0;
        @(negedge clk);
        while (!ov_i && w < 10) begin @(negedge clk); w++; end
        for (int s = 0; s < 5; s++) begin
            check($sformatf("it_hold%0d_data", s), int'(od_i), 'h4B);
            check($sformatf("it_hold%0d_out_valid", s), int'(ov_i), 1);
            check($sformatf("it_hold%0d_in_ready", s), int'(ir_i), 0);
            @(negedge clk);
        end
        @(posedge clk); #1 ordy_i = 1'b1;
        @(posedge clk); #1;

        // Key write while idle: K2 = 0 on both instances
        we_h = 1'b1; we_i = 1'b1; cfg_sel = 2'd2; cfg_data = 8'h00;
        @(posedge clk); #1 we_h = 1'b0; we_i = 1'b0;
        km2 = 8'h00;
        run_vec(1'b1, enc(8'h5A), 8'h5A, "k2zero");
        run_vec(1'b0, enc(8'hC3), 8'hC3, "k2zero");

        // Key write while a byte is in flight must be dropped
        iv_h = 1'b1; id_h = enc(8'h3E);
        @(posedge clk); #1;
        iv_h = 1'b0; we_h = 1'b1; cfg_sel = 2'd2; cfg_data = 8'h55;
        @(posedge clk); #1 we_h = 1'b0;
        w = 0;
        @(negedge clk);
        while (!ov_h && w < 10) begin @(negedge clk); w++; end
        check("inflight_byte_data", int'(od_h), 'h3E);
        @(posedge clk); #1;
        run_vec(1'b1, enc(8'h71), 8'h71, "dropped_write");

        // Writes to the reserved index change nothing
        we_h = 1'b1; we_i = 1'b1; cfg_sel = 2'd0; cfg_data = 8'hFF;
        @(posedge clk); #1 we_h = 1'b0; we_i = 1'b0;
        run_vec(1'b1, enc(8'h0F), 8'h0F, "sel0_write");
        run_vec(1'b0, enc(8'hF0), 8'hF0, "sel0_write");

        // Reset with bytes in flight
        iv_h = 1'b1; id_h = enc(8'h11); iv_i = 1'b1; id_i = enc(8'h22);
        @(posedge clk); #1;
        id_h = enc(8'h33); iv_i = 1'b0;
        @(posedge clk); #1;
        iv_h = 1'b0; reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        seen = 0;
        for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            if (ov_h || ov_i) seen++;
        end
        check("midrst_no_output", seen, 0);
        check("midrst_hp_idle", int'(idle_h), 1);
        check("midrst_it_idle", int'(idle_i), 1);
        @(posedge clk); #1;
        km2 = 8'd167;
        run_vec(1'b1, 8'h00, 8'h1D, "midrst_keys");
        run_vec(1'b0, 8'h00, 8'h1D, "midrst_keys");
        run_vec(1'b1, 8'h8D, 8'h00, "midrst_keys2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
